// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [1:0] MEMCTL_NONE = 2'b00;
  localparam logic [1:0] MEMCTL_WR   = 2'b01;
  localparam logic [1:0] MEMCTL_RD   = 2'b10;

  localparam logic [1:0] WB_NONE     = 2'b00;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEST_W = 4;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads a completed instruction or inserts a bubble
// (out_valid=0, wb cleared, payload held).
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEST_W = DEF_DEST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DEST_W-1:0] dest_d,
  input  logic [DATA_W-1:0] memdata_d,
  input  logic [DATA_W-1:0] regdata_d,
  input  logic [1:0]        wb_d,
  output logic              out_valid,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] regData,
  output logic [1:0]        wb
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dest      <= '0;
      memData   <= '0;
      regData   <= '0;
      wb        <= WB_NONE;
    end else if (load) begin
      out_valid <= 1'b1;
      dest      <= dest_d;
      memData   <= memdata_d;
      regData   <= regdata_d;
      wb        <= wb_d;
    end else begin
      out_valid <= 1'b0;
      wb        <= WB_NONE;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over req/ack, stalls upstream
// while an access is outstanding. Optional access timeout: MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEST_W  = DEF_DEST_W
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [1:0]        mem_ctl,
  input  logic [1:0]        wb_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] memData,
  output logic [DATA_W-1:0] regData,
  output logic [1:0]        wb
`ifdef MEM_TIMEOUT_EN
  ,
  output logic              mem_err
`endif
);

  state_t            state, state_nx;
  logic [DEST_W-1:0] dest_l;
  logic [1:0]        wb_l;
  logic              rd_l;
  logic              issue_alu, issue_mem, done, abort;

  logic              wbr_load;
  logic [DEST_W-1:0] wbr_dest;
  logic [DATA_W-1:0] wbr_mem;
  logic [DATA_W-1:0] wbr_reg;
  logic [1:0]        wbr_wb;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  // cnt counts completed ACCESS cycles without ack; the TIMEOUT-th such cycle aborts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= abort;
      if (issue_mem)
        cnt <= '0;
      else if (state == ACCESS && !mem_ack)
        cnt <= cnt + 1'b1;
    end
  end

  assign abort = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  assign stall = (state == ACCESS);

  always_comb begin
    state_nx  = state;
    issue_alu = 1'b0;
    issue_mem = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (mem_ctl == MEMCTL_NONE) begin
            issue_alu = 1'b1;
          end else begin
            issue_mem = 1'b1;
            state_nx  = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack || abort) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wbr_load = issue_alu | done;
    wbr_dest = dest_in;
    wbr_reg  = alu_result;
    wbr_wb   = wb_in;
    wbr_mem  = '0;
    if (state == ACCESS) begin
      wbr_dest = dest_l;
      wbr_reg  = mem_addr;
      wbr_wb   = abort ? WB_NONE : wb_l;
      wbr_mem  = (mem_ack && rd_l) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dest_l    <= '0;
      wb_l      <= WB_NONE;
      rd_l      <= 1'b0;
    end else begin
      state <= state_nx;
      if (issue_mem) begin
        mem_req   <= 1'b1;
        mem_we    <= (mem_ctl == MEMCTL_WR);
        mem_addr  <= alu_result;
        mem_wdata <= store_data;
        dest_l    <= dest_in;
        wb_l      <= wb_in;
        rd_l      <= (mem_ctl & MEMCTL_RD) != MEMCTL_NONE;
      end else if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .DEST_W (DEST_W)
  ) u_mem_wb_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (wbr_load),
    .dest_d    (wbr_dest),
    .memdata_d (wbr_mem),
    .regdata_d (wbr_reg),
    .wb_d      (wbr_wb),
    .out_valid (out_valid),
    .dest      (dest),
    .memData   (memData),
    .regData   (regData),
    .wb        (wb)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, directed multi-cycle cases,
// and randomized transactions against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [3:0]  dest_in;
  logic [1:0]  mem_ctl;
  logic [1:0]  wb_in;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [3:0]  dest;
  logic [31:0] memData;
  logic [31:0] regData;
  logic [1:0]  wb;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int tests = 0;
  int fails = 0;

  mem_stage #(
    .DATA_W (32),
    .DEST_W (4)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT (4)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .alu_result (alu_result),
    .store_data (store_data),
    .dest_in    (dest_in),
    .mem_ctl    (mem_ctl),
    .wb_in      (wb_in),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .dest       (dest),
    .memData    (memData),
    .regData    (regData),
    .wb         (wb)
`ifdef MEM_TIMEOUT_EN
    ,
    .mem_err    (mem_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [3:0] d,
                           input logic [31:0] r, input logic [31:0] m, input logic [1:0] w);
    check({name, ".out_valid"}, out_valid, v);
    check({name, ".dest"}, dest, d);
    check({name, ".regData"}, regData, r);
    check({name, ".memData"}, memData, m);
    check({name, ".wb"}, wb, w);
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    mem_ctl    = 2'b00;
    alu_result = '0;
    store_data = '0;
    dest_in    = '0;
    wb_in      = 2'b00;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        vin;
    logic [1:0]  ctl;
    logic [31:0] alu;
    logic [3:0]  dst;
    logic [1:0]  wbi;
    logic        ev;
    logic [3:0]  ed;
    logic [31:0] er;
    logic [1:0]  ew;
  } vec_t;

  vec_t vecs [6];

  logic [1:0]  r_ctl, r_wb;
  logic [31:0] r_alu, r_sd, r_rd, m_mem;
  logic [3:0]  r_dst;
  int unsigned r_lat, r_gap;

  initial begin
    // ALU pass-through and bubble sequence, applied in order from reset
    vecs[0] = '{1'b1, 2'b00, 32'h0000_1234, 4'd5,  2'b01, 1'b1, 4'd5,  32'h0000_1234, 2'b01};
    vecs[1] = '{1'b0, 2'b10, 32'hFFFF_FFFF, 4'd9,  2'b11, 1'b0, 4'd5,  32'h0000_1234, 2'b00};
    vecs[2] = '{1'b1, 2'b00, 32'hCAFE_0001, 4'd15, 2'b11, 1'b1, 4'd15, 32'hCAFE_0001, 2'b11};
    vecs[3] = '{1'b1, 2'b00, 32'h0000_0000, 4'd0,  2'b10, 1'b1, 4'd0,  32'h0000_0000, 2'b10};
    vecs[4] = '{1'b0, 2'b00, 32'h0000_0055, 4'd3,  2'b01, 1'b0, 4'd0,  32'h0000_0000, 2'b00};
    vecs[5] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 4'd10, 2'b01, 1'b1, 4'd10, 32'hFFFF_FFFF, 2'b01};

    do_reset();
    check_out("reset", 1'b0, 4'd0, 32'h0, 32'h0, 2'b00);
    check("reset.stall", stall, 1'b0);
    check("reset.mem_req", mem_req, 1'b0);
    check("reset.mem_we", mem_we, 1'b0);
    check("reset.mem_addr", mem_addr, 32'h0);
    check("reset.mem_wdata", mem_wdata, 32'h0);
`ifdef MEM_TIMEOUT_EN
    check("reset.mem_err", mem_err, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      in_valid   = vecs[i].vin;
      mem_ctl    = vecs[i].ctl;
      alu_result = vecs[i].alu;
      dest_in    = vecs[i].dst;
      wb_in      = vecs[i].wbi;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].er, 32'h0, vecs[i].ew);
      check($sformatf("vec%0d.stall", i), stall, 1'b0);
      check($sformatf("vec%0d.mem_req", i), mem_req, 1'b0);
    end

    // Load, ack during the third request cycle
    in_valid = 1'b1; mem_ctl = 2'b10; alu_result = 32'h40; dest_in = 4'd3; wb_in = 2'b11;
    tick();
    check("ld.req", mem_req, 1'b1);
    check("ld.addr", mem_addr, 32'h40);
    check("ld.we", mem_we, 1'b0);
    check("ld.stall", stall, 1'b1);
    check("ld.bubble_valid", out_valid, 1'b0);
    check("ld.bubble_wb", wb, 2'b00);
    in_valid = 1'b1; mem_ctl = 2'b00; alu_result = 32'h999;
    tick();
    check("ld.req2", mem_req, 1'b1);
    check("ld.addr2", mem_addr, 32'h40);
    tick();
    check("ld.req3", mem_req, 1'b1);
    check("ld.stall3", stall, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; in_valid = 1'b0;
    check_out("ld.done", 1'b1, 4'd3, 32'h40, 32'hDEAD_BEEF, 2'b11);
    check("ld.done_stall", stall, 1'b0);
    check("ld.done_req", mem_req, 1'b0);

    // Store acked in the first request cycle
    in_valid = 1'b1; mem_ctl = 2'b01; store_data = 32'hA5A5_A5A5; alu_result = 32'h80;
    dest_in = 4'd7; wb_in = 2'b01;
    tick();
    in_valid = 1'b0;
    check("st.req", mem_req, 1'b1);
    check("st.we", mem_we, 1'b1);
    check("st.wdata", mem_wdata, 32'hA5A5_A5A5);
    check("st.addr", mem_addr, 32'h80);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    check("st.req_drop", mem_req, 1'b0);
    check("st.we_drop", mem_we, 1'b0);
    check_out("st.done", 1'b1, 4'd7, 32'h80, 32'h0, 2'b01);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    tick();
    mem_ack = 1'b0;
    check_out("idle_ack", 1'b0, 4'd7, 32'h80, 32'h0, 2'b00);
    check("idle_ack.req", mem_req, 1'b0);
    check("idle_ack.stall", stall, 1'b0);

    // Reset during the second ACCESS cycle, then a late ack
    in_valid = 1'b1; mem_ctl = 2'b11; alu_result = 32'h100; dest_in = 4'd2; wb_in = 2'b10;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_mid.req_before", mem_req, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid.req", mem_req, 1'b0);
    check("rst_mid.stall", stall, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    check_out("rst_mid.late_ack", 1'b0, 4'd0, 32'h0, 32'h0, 2'b00);
    check("rst_mid.late_req", mem_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
    // Load never acked: aborts after 4 ACCESS cycles
    in_valid = 1'b1; mem_ctl = 2'b10; alu_result = 32'h200; dest_in = 4'd6; wb_in = 2'b11;
    tick();
    in_valid = 1'b0;
    check("to.req1", mem_req, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("to.req%0d", k), mem_req, 1'b1);
      check($sformatf("to.err%0d", k), mem_err, 1'b0);
    end
    tick();
    check("to.req_drop", mem_req, 1'b0);
    check("to.err", mem_err, 1'b1);
    check("to.stall", stall, 1'b0);
    check_out("to.out", 1'b1, 4'd6, 32'h200, 32'h0, 2'b00);
    tick();
    check("to.err_pulse", mem_err, 1'b0);
    check("to.after_valid", out_valid, 1'b0);

    // Ack on the timeout cycle completes normally
    in_valid = 1'b1; mem_ctl = 2'b10; alu_result = 32'h300; dest_in = 4'd8; wb_in = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    tick();
    mem_ack = 1'b0;
    check("to_ack.err", mem_err, 1'b0);
    check_out("to_ack.out", 1'b1, 4'd8, 32'h300, 32'h1357_9BDF, 2'b01);
`endif

    // Randomized transactions; model holds the last loaded WB payload
    do_reset();
    for (int t = 0; t < 40; t++) begin
      r_ctl = 2'($urandom_range(0, 3));
      r_alu = $urandom;
      r_sd  = $urandom;
      r_rd  = $urandom;
      r_dst = 4'($urandom_range(0, 15));
      r_wb  = 2'($urandom_range(0, 3));
      r_lat = $urandom_range(0, 3);
      r_gap = $urandom_range(0, 2);
      in_valid = 1'b1; mem_ctl = r_ctl; alu_result = r_alu; store_data = r_sd;
      dest_in = r_dst; wb_in = r_wb;
      tick();
      m_mem = 32'h0;
      if (r_ctl != 2'b00) begin
        check("rnd.req", mem_req, 1'b1);
        check("rnd.we", mem_we, r_ctl == 2'b01);
        check("rnd.addr", mem_addr, r_alu);
        check("rnd.wdata", mem_wdata, r_sd);
        check("rnd.stall", stall, 1'b1);
        check("rnd.bubble", out_valid, 1'b0);
        in_valid = 1'($urandom_range(0, 1));
        mem_ctl = 2'($urandom_range(0, 3));
        alu_result = $urandom;
        for (int unsigned k = 0; k < r_lat; k++) begin
          tick();
          check("rnd.wait_req", mem_req, 1'b1);
          check("rnd.wait_addr", mem_addr, r_alu);
          check("rnd.wait_valid", out_valid, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = r_rd;
        tick();
        mem_ack = 1'b0;
        m_mem = r_ctl[1] ? r_rd : 32'h0;
      end
      in_valid = 1'b0;
      check_out("rnd.done", 1'b1, r_dst, r_alu, m_mem, r_wb);
      check("rnd.done_stall", stall, 1'b0);
      check("rnd.done_req", mem_req, 1'b0);
      for (int unsigned g = 0; g < r_gap; g++) begin
        tick();
        check_out("rnd.gap", 1'b0, r_dst, r_alu, m_mem, 2'b00);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
